// File: rtl/vec_data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vec_data_mem_arbiter_pkg -- helpers local to the VecDataMem arbiter.
//
// wrap_idx : (base + off) mod n. This is the rotate step of the priority search.
// cnt_bits : the width needed to hold a count of 0..max_val.
// -----------------------------------------------------------------------------
package vec_data_mem_arbiter_pkg;

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg -- shared vector-datapath types.
//
// Holds the VecDataMem write-op encoding and the default memory word type.
// Each lane is an IEEE-754 single-precision value. The lane is carried as its
// raw 32-bit pattern so that the type is synthesizable.
// -----------------------------------------------------------------------------
package vec_pkg;

    localparam int VEC_LANE_BITS   = 32;
    localparam int VEC_WIDTH       = 16;
    localparam int VEC_ARB_MAX_REQ = 16;

    typedef enum logic [1:0] {
        VDM_WRITE_NOP    = 2'd0,
        VDM_WRITE_FULL   = 2'd1,
        VDM_WRITE_MASKED = 2'd2
    } VecDataMemWriteOp_t;

    // One memory word: VEC_WIDTH single-precision lanes.
    typedef logic [VEC_WIDTH-1:0][VEC_LANE_BITS-1:0] vec_word_t;

endpackage

// File: rtl/vec_data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// vec_data_mem_arbiter_if -- requester-side bus of the VecDataMem arbiter.
//
// Signals
//   req_valid/req_write/req_addr/req_data : per-requester request (master out)
//   req_lock                              : per-requester burst lock, only
//                                           present with VEC_MEM_ARB_LOCK_EN
//   req_ready                             : one-hot grant (slave out)
//   resp_valid/resp_id/resp_data          : registered read response (slave out)
// Modports: master (requesters / testbench), slave (arbiter).
// -----------------------------------------------------------------------------
interface vec_data_mem_arbiter_if
    import vec_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32
);
    localparam int ID_SIZE = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                              req_valid;
    logic [NUM_REQ-1:0]                              req_write;
    logic [NUM_REQ-1:0][DATA_MEM_ADDR_SIZE-1:0]      req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0][VEC_LANE_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]                              req_ready;
`ifdef VEC_MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]                              req_lock;
`endif
    logic                                            resp_valid;
    logic [ID_SIZE-1:0]                              resp_id;
    logic [WIDTH-1:0][VEC_LANE_BITS-1:0]             resp_data;

`ifdef VEC_MEM_ARB_LOCK_EN
    modport master (output req_valid, req_write, req_addr, req_data, req_lock,
                    input  req_ready, resp_valid, resp_id, resp_data);
    modport slave  (input  req_valid, req_write, req_addr, req_data, req_lock,
                    output req_ready, resp_valid, resp_id, resp_data);
`else
    modport master (output req_valid, req_write, req_addr, req_data,
                    input  req_ready, resp_valid, resp_id, resp_data);
    modport slave  (input  req_valid, req_write, req_addr, req_data,
                    output req_ready, resp_valid, resp_id, resp_data);
`endif

endinterface

// File: rtl/vec_data_mem_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick -- combinational rotate-priority encoder.
//
// The search starts at ptr+1 and wraps modulo NUM_REQ. The first set bit of
// req wins.
// Ports
//   req    : request vector
//   ptr    : last winner; it has the lowest priority
//   onehot : one-hot winner, all zero when req == 0
//   idx    : winner index, 0 when req == 0
//   found  : some request is pending
// -----------------------------------------------------------------------------
module rr_priority_pick
    import vec_data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_SIZE = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_SIZE-1:0] ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_SIZE-1:0] idx,
    output logic               found
);

    logic [ID_SIZE-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        // i == NUM_REQ lands back on ptr itself. This keeps a lone requester
        // granted every cycle.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_SIZE'(wrap_idx(int'(ptr), i, NUM_REQ));
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vec_data_mem_arbiter -- round-robin sharing of one VecDataMem port.
//
// At most one transfer is granted per cycle.
// - A write grant drives the memory write port in the same cycle. The memory
//   commits it at the clock edge.
// - A read grant drives the combinational read address. The data is registered
//   and returned with the requester ID one cycle later.
//
// Ports
//   clock, reset   : clock and asynchronous active-high reset
//   bus (slave)    : requester handshake and read response
//   mem_read_addr  : VecDataMem read_addr. Holds its last value when idle.
//   mem_data_out   : VecDataMem data_out (combinational)
//   mem_write_op   : VecDataMem write_op. It is a no-op when no write is granted.
//   mem_write_addr : VecDataMem write_addr
//   mem_data_in    : VecDataMem data_in
//
// Optional feature: macro VEC_MEM_ARB_LOCK_EN enables burst locking. While the
// last winner keeps req_valid and req_lock asserted, it keeps the grant. After
// MAX_BURST consecutive locked grants, the lock is ignored for one arbitration.
// -----------------------------------------------------------------------------
module vec_data_mem_arbiter
    import vec_pkg::*;
    import vec_data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int MAX_BURST          = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    vec_data_mem_arbiter_if.slave               bus,
    output logic [DATA_MEM_ADDR_SIZE-1:0]       mem_read_addr,
    input  logic [WIDTH-1:0][VEC_LANE_BITS-1:0] mem_data_out,
    output VecDataMemWriteOp_t                  mem_write_op,
    output logic [DATA_MEM_ADDR_SIZE-1:0]       mem_write_addr,
    output logic [WIDTH-1:0][VEC_LANE_BITS-1:0] mem_data_in
);

    localparam int ID_SIZE = $clog2(NUM_REQ);

    if ((NUM_REQ < 2) || (NUM_REQ > VEC_ARB_MAX_REQ) || (MAX_BURST < 1)) begin : g_cfg_check
        $error("vec_data_mem_arbiter: NUM_REQ must be 2..16 and MAX_BURST >= 1");
    end

    logic [ID_SIZE-1:0]            rr_ptr;
    logic [DATA_MEM_ADDR_SIZE-1:0] read_addr_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_SIZE-1:0] pick_idx;
    logic               pick_found;

    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_SIZE-1:0] win_idx;
    logic               grant;
    logic               wr_grant;
    logic               rd_grant;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_SIZE (ID_SIZE)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

`ifdef VEC_MEM_ARB_LOCK_EN
    localparam int BURST_W = cnt_bits(MAX_BURST);

    logic [BURST_W-1:0] burst_cnt;
    logic               burst_full;
    logic               lock_hold;

    always_comb begin
        burst_full = (burst_cnt == BURST_W'(MAX_BURST));
        // rr_ptr doubles as "last winner", so a held lock simply re-grants it.
        lock_hold  = bus.req_valid[rr_ptr] & bus.req_lock[rr_ptr] & ~burst_full;
        win_idx    = lock_hold ? rr_ptr : pick_idx;
        win_onehot = lock_hold ? (NUM_REQ'(1) << rr_ptr) : pick_onehot;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (grant) begin
            if (burst_full)
                burst_cnt <= '0;
            else if (bus.req_lock[win_idx])
                burst_cnt <= (win_idx == rr_ptr) ? burst_cnt + 1'b1 : BURST_W'(1);
            else
                burst_cnt <= '0;
        end
    end
`else
    assign win_idx    = pick_idx;
    assign win_onehot = pick_onehot;
`endif

    // Grant is suppressed while reset is held, so no memory op leaks out.
    assign grant    = pick_found & ~reset;
    assign wr_grant = grant &  bus.req_write[win_idx];
    assign rd_grant = grant & ~bus.req_write[win_idx];

    assign bus.req_ready   = grant ? win_onehot : '0;
    assign mem_write_op    = wr_grant ? VDM_WRITE_FULL : VDM_WRITE_NOP;
    assign mem_write_addr  = wr_grant ? bus.req_addr[win_idx] : '0;
    assign mem_data_in     = wr_grant ? bus.req_data[win_idx] : '0;
    assign mem_read_addr   = rd_grant ? bus.req_addr[win_idx] : read_addr_q;

    // ---- grant cycle -> response register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr         <= ID_SIZE'(NUM_REQ - 1);
            read_addr_q    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_data  <= '0;
        end else begin
            bus.resp_valid <= rd_grant;
            if (grant)
                rr_ptr <= win_idx;
            if (rd_grant) begin
                read_addr_q   <= bus.req_addr[win_idx];
                bus.resp_id   <= win_idx;
                bus.resp_data <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_vec_data_mem_arbiter.sv
module tb_vec_data_mem_arbiter;
    import vec_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int AW      = 32;

    typedef logic [WIDTH-1:0][31:0] word_t;
    typedef struct packed {
        logic [1:0] id;
        word_t      data;
    } exp_t;

    localparam logic [31:0] F_ONE = 32'h3F80_0000;
    localparam logic [31:0] F_TWO = 32'h4000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vec_data_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DATA_MEM_ADDR_SIZE(AW)) bus ();

    logic [AW-1:0]      mem_read_addr;
    logic [AW-1:0]      mem_write_addr;
    word_t              mem_data_out;
    word_t              mem_data_in;
    VecDataMemWriteOp_t mem_write_op;

    vec_data_mem_arbiter #(
        .NUM_REQ            (NUM_REQ),
        .WIDTH              (WIDTH),
        .DATA_MEM_ADDR_SIZE (AW),
        .MAX_BURST          (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mem_read_addr  (mem_read_addr),
        .mem_data_out   (mem_data_out),
        .mem_write_op   (mem_write_op),
        .mem_write_addr (mem_write_addr),
        .mem_data_in    (mem_data_in)
    );

    // Environment model of VecDataMem. Unwritten words read as pattern(addr).
    word_t mem     [256];
    bit    written [256];

    function automatic word_t pattern(input logic [AW-1:0] a);
        word_t w;
        for (int k = 0; k < WIDTH; k++)
            w[k] = F_ONE + {16'h0, a[7:0], 8'(k)};
        return w;
    endfunction

    function automatic word_t splat(input logic [31:0] v);
        word_t w;
        for (int k = 0; k < WIDTH; k++) w[k] = v;
        return w;
    endfunction

    assign mem_data_out = written[mem_read_addr[7:0]] ? mem[mem_read_addr[7:0]]
                                                      : pattern(mem_read_addr);

    always @(posedge clock) begin
        if (mem_write_op == VDM_WRITE_FULL) begin
            mem[mem_write_addr[7:0]]     <= mem_data_in;
            written[mem_write_addr[7:0]] <= 1'b1;
        end
    end

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
`ifdef VEC_MEM_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input word_t d);
        bus.req_valid[i] = 1'b1;
        bus.req_write[i] = wr;
        bus.req_addr[i]  = a;
        bus.req_data[i]  = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        reset = 1'b1;
        set_req(0, 1'b1, 32'd9, splat(F_ONE));
        tick();
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000 || mem_write_op !== VDM_WRITE_NOP) begin
            miscompares++;
            $display("FAIL reset_gate ready=%b op=%0d want ready=0000 op=0", bus.req_ready, mem_write_op);
        end
        idle();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 0000", bus.req_ready);
        end
        vectors++;
        if (mem_write_op !== VDM_WRITE_NOP) begin
            miscompares++;
            $display("FAIL reset_wop got %0d want 0", mem_write_op);
        end
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.resp_id !== 2'd0 || bus.resp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_resp valid=%b id=%0d d0=%h want 0/0/0", bus.resp_valid, bus.resp_id, bus.resp_data[0]);
        end
        vectors++;
        if (mem_read_addr !== '0 || mem_write_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr rd=%h wr=%h want 0/0", mem_read_addr, mem_write_addr);
        end
        vectors++;
        if (dut.rr_ptr !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_rr_ptr got %0d want 3", dut.rr_ptr);
        end
        e = '0;
        if (e.id !== 2'd0) $display("note: scoreboard entry default nonzero");
    endtask

    task automatic test_write_then_read();
        exp_t e;
        idle();
        set_req(0, 1'b1, 32'd5, splat(F_ONE));
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001 || mem_write_op !== VDM_WRITE_FULL ||
            mem_write_addr !== 32'd5 || mem_data_in !== splat(F_ONE)) begin
            miscompares++;
            $display("FAIL wr_grant ready=%b op=%0d addr=%0d d0=%h want 0001/1/5/%h",
                     bus.req_ready, mem_write_op, mem_write_addr, mem_data_in[0], F_ONE);
        end
        tick();
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_no_resp resp_valid got %b want 0", bus.resp_valid);
        end
        idle();
        set_req(2, 1'b0, 32'd5, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100 || mem_read_addr !== 32'd5 || mem_write_op !== VDM_WRITE_NOP) begin
            miscompares++;
            $display("FAIL raw_grant ready=%b raddr=%0d op=%0d want 0100/5/0", bus.req_ready, mem_read_addr, mem_write_op);
        end
        e.id = 2'd2; e.data = splat(F_ONE); sb.push_back(e);
        tick();
        idle();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL raw_resp valid=%b id=%0d d0=%h want 1/%0d/%h", bus.resp_valid, bus.resp_id, bus.resp_data[0], e.id, e.data[0]);
            end
        end
        #1;
        vectors++;
        if (mem_read_addr !== 32'd5) begin
            miscompares++;
            $display("FAIL raddr_hold got %0d want 5", mem_read_addr);
        end
        tick();
    endtask

    task automatic test_rotation();
        exp_t       e;
        logic [3:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            idle();
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'(16 + i), '0);
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            vectors++;
            if (bus.req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rot_grant cycle %0d got %b want %b", c, bus.req_ready, exp_rdy);
            end
            e.id = 2'(c % 4); e.data = pattern(32'(16 + c % 4)); sb.push_back(e);
            tick();
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rot_resp cycle %0d valid=%b id=%0d d0=%h want 1/%0d/%h", c, bus.resp_valid, bus.resp_id, bus.resp_data[0], e.id, e.data[0]);
                end
            end
        end
        idle();
        tick();
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rot_idle resp_valid got %b want 0", bus.resp_valid);
        end
    endtask

    task automatic test_deassert();
        exp_t e;
        do_reset();
        set_req(0, 1'b0, 32'd30, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL deas_first got %b want 0001", bus.req_ready);
        end
        e.id = 2'd0; e.data = pattern(32'd30); sb.push_back(e);
        tick();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL deas_resp0 valid=%b id=%0d want 1/%0d", bus.resp_valid, bus.resp_id, e.id);
            end
        end
        idle();
        set_req(1, 1'b0, 32'd31, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL deas_req1 got %b want 0010", bus.req_ready);
        end
        bus.req_valid[1] = 1'b0;
        set_req(3, 1'b0, 32'd33, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL deas_req3 got %b want 1000", bus.req_ready);
        end
        e.id = 2'd3; e.data = pattern(32'd33); sb.push_back(e);
        tick();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL deas_resp3 valid=%b id=%0d d0=%h want 1/%0d/%h", bus.resp_valid, bus.resp_id, bus.resp_data[0], e.id, e.data[0]);
            end
        end
        vectors++;
        if (dut.rr_ptr !== 2'd3) begin
            miscompares++;
            $display("FAIL deas_rr_ptr got %0d want 3", dut.rr_ptr);
        end
        idle();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'(40 + i), '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL deas_wrap got %b want 0001", bus.req_ready);
        end
        e.id = 2'd0; e.data = pattern(32'd40); sb.push_back(e);
        tick();
        idle();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL deas_resp_wrap valid=%b id=%0d want 1/%0d", bus.resp_valid, bus.resp_id, e.id);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        set_req(0, 1'b1, 32'd7, splat(F_TWO));
        #1;
        tick();
        idle();
        set_req(1, 1'b0, 32'd7, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_grant got %b want 0010", bus.req_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000 || dut.rr_ptr !== 2'd3) begin
            miscompares++;
            $display("FAIL mid_reset valid=%b ready=%b rr_ptr=%0d want 0/0000/3", bus.resp_valid, bus.req_ready, dut.rr_ptr);
        end
        idle();
        tick();
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_dropped resp_valid got %b want 0", bus.resp_valid);
        end
        reset = 1'b0;
        set_req(2, 1'b0, 32'd7, '0);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_after got %b want 0100", bus.req_ready);
        end
        e.id = 2'd2; e.data = splat(F_TWO); sb.push_back(e);
        tick();
        idle();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL mid_committed valid=%b id=%0d d0=%h want 1/%0d/%h", bus.resp_valid, bus.resp_id, bus.resp_data[0], e.id, e.data[0]);
            end
        end
        tick();
    endtask

`ifdef VEC_MEM_ARB_LOCK_EN
    task automatic test_lock_burst();
        exp_t       e;
        logic [3:0] exp_rdy;
        do_reset();
        set_req(0, 1'b0, 32'd50, '0);
        bus.req_lock[0] = 1'b1;
        set_req(1, 1'b0, 32'd51, '0);
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_rdy = (c < 8) ? 4'b0001 : 4'b0010;
            vectors++;
            if (bus.req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL lock_grant cycle %0d got %b want %b", c, bus.req_ready, exp_rdy);
            end
            e.id = (c < 8) ? 2'd0 : 2'd1;
            e.data = pattern((c < 8) ? 32'd50 : 32'd51);
            sb.push_back(e);
            tick();
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== e.id || bus.resp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL lock_resp cycle %0d valid=%b id=%0d want 1/%0d", c, bus.resp_valid, bus.resp_id, e.id);
                end
            end
        end
        vectors++;
        if (dut.burst_cnt !== '0) begin
            miscompares++;
            $display("FAIL lock_cnt got %0d want 0", dut.burst_cnt);
        end
        idle();
        tick();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_write_then_read();
        test_rotation();
        test_deassert();
        test_reset_mid();
`ifdef VEC_MEM_ARB_LOCK_EN
        test_lock_burst();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
